mips_ctrl_pipe: RTL and testbench
=================================

// Module: mips_ctrl_pipe
// PURPOSE
//  Downstream consumer of the ID-stage decoded control bundle: carries it through the ID/EX, EX/MEM
//  and MEM/WB control registers. Resolves branch, jump and jump-register redirects. Detects
//  load-use hazards, produces stall/flush controls, and selects EX-operand forwarding paths.
//  Sits between the decoder and the datapath pipeline registers of the pipelined MIPS core.
// PARAMETERS
//  REGW    5   register-address width
//  RA_REG  31  link register written when regdst==2'b10 (jal)
// PORTS
//  clk          in   1     rising-edge clock
//  reset_n      in   1     asynchronous active-low reset
//  d_valid      in   1     ID holds a real instruction (0 = bubble)
//  d_regwrite   in   1     decoded controls for the instruction in ID
//  d_memwrite   in   1
//  d_alusrc     in   1
//  d_branch     in   1
//  d_jump       in   1
//  d_jump_r     in   1
//  d_memtoreg   in   2     00 alu, 01 mem, 10 pc+4
//  d_regdst     in   2     00 rt, 01 rd, 10 RA_REG
//  d_alucontrol in   3
//  d_rs, d_rt, d_rd in REGW  register fields of the ID instruction
//  e_zero       in   1     ALU zero flag of the instruction in EX
//  e_alusrc     out  1     EX-stage controls (registered)
//  e_alucontrol out  3
//  e_forwarda   out  2     00 regfile, 01 from WB result, 10 from MEM ALU result
//  e_forwardb   out  2
//  m_memwrite   out  1     MEM-stage control (registered)
//  w_regwrite   out  1     WB-stage controls (registered)
//  w_memtoreg   out  2
//  w_writereg   out  REGW
//  pcsrc        out  1     taken branch in EX -> PC = branch target
//  pc_jr        out  1     jr in EX -> PC = forwarded rs operand
//  pc_jump      out  1     jump in ID -> PC = jump target
//  stall_f      out  1     hold PC
//  stall_d      out  1     hold IF/ID register
//  flush_d      out  1     clear IF/ID register
// BEHAVIOUR
//  - Reset (async, reset_n=0): all stage registers = bubble (every control 0, writereg 0).
//    All outputs 0 while held and on the first cycle after release.
//  - Stage regs: ID/EX loads the ID bundle + rs/rt/rd. EX/MEM and MEM/WB always advance.
//  - e_writereg is formed in EX from regdst: rt / rd / RA_REG. The regdst==11 encoding gives rt.
//    It is then carried to MEM and WB.
//  - Load-use: lw_stall = e_valid & e_regwrite & e_memtoreg==01 & e_writereg!=0 &
//    (e_writereg==d_rs | e_writereg==d_rt).
//    Response: stall_f = stall_d = 1, and ID/EX loads a bubble. Exactly one stall cycle.
//  - pcsrc = e_branch & e_zero; pc_jr = e_jump_r. Either of these (redirect_e) causes:
//    flush_d = 1, ID/EX loads a bubble next edge, stall outputs forced 0.
//  - pc_jump = d_valid & d_jump & ~redirect_e. pc_jump also sets flush_d. ID/EX still takes
//    the jump (jal must reach WB).
//  - Priority: redirect_e > lw_stall > pc_jump. With redirect_e, lw_stall and pc_jump are
//    masked. With lw_stall, pc_jump is masked (the jump is re-presented next cycle).
//  - Forward A (rs of EX):
//      10 if m_regwrite & m_writereg!=0 & m_writereg==e_rs
//      else 01 if w_regwrite & w_writereg!=0 & w_writereg==e_rs
//      else 00.
//    Forward B uses e_rt with the same rule. MEM beats WB on a double match.
//  - Register 0 is never a hazard or forward source.
//  - Combinational outputs depend only on stage registers plus d_* inputs. No comb path from
//    e_zero to stall_*.
//  - Bubble = d_valid forced 0 with all controls 0. A bubble never writes, branches or stalls.
// STRUCTURE
//  - Package mips_decls_p gains:
//      ctrl_bundle_t (packed struct of all d_* control fields + valid)
//      fwd_sel_t enum {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}
//      regdst_t / memtoreg_t enums
//      localparam BUBBLE of type ctrl_bundle_t
//  - One sub-module: ctrl_stage_reg #(type T). Holds one stage: async reset to BUBBLE,
//    inputs en (hold when 0) and clr (load BUBBLE). Instantiated three times.
//    Hazard/forward logic stays in this module.
// TESTING
//  1. Reset: drive reset_n=0 mid-stream with a lw in EX -> all outputs 0 immediately; clean
//     restart after release.
//  2. lw $t0 then add $t1,$t0,$t2 -> one cycle of stall_f=stall_d=1 with a bubble in EX,
//     then e_forwarda=01.
//  3. add $t0; add $t1,$t0,$t0 -> e_forwarda=e_forwardb=10. With one instruction between
//     -> 01. Write to $0 -> 00.
//  4. beq in EX with e_zero=1, while ID holds a lw-dependent add -> pcsrc=1, flush_d=1,
//     stall_*=0, bubble in EX next cycle.
//  5. jal in ID -> pc_jump=1, flush_d=1. Three cycles later w_writereg=31, w_memtoreg=10,
//     w_regwrite=1.
//  6. jr in EX while ID holds j -> pc_jr=1, pc_jump=0. Next cycle EX holds a bubble.

Source files
------------

// File: rtl/mips_decls_p.sv
// rtl/mips_decls_p.sv - shared control-pipeline types for the pipelined MIPS core
package mips_decls_p;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RD_RT  = 2'b00,
    RD_RD  = 2'b01,
    RD_RA  = 2'b10,
    RD_RSV = 2'b11
  } regdst_t;

  typedef enum logic [1:0] {
    MTR_ALU = 2'b00,
    MTR_MEM = 2'b01,
    MTR_PC4 = 2'b10,
    MTR_RSV = 2'b11
  } memtoreg_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       jump_r;
    memtoreg_t  memtoreg;
    regdst_t    regdst;
    logic [2:0] alucontrol;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      MTR_ALU, RD_RT, 3'b000};

endpackage

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - one pipeline control stage register with hold and bubble-clear
module ctrl_stage_reg #(
  parameter type T       = logic,
  parameter T    RST_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  T     d,
  output T     q
);

  T q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else if (clr) begin
      q_q <= RST_VAL;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mips_ctrl_pipe.sv
// rtl/mips_ctrl_pipe.sv - ID/EX/MEM/WB control pipeline with redirects, load-use stall and forwarding
module mips_ctrl_pipe
  import mips_decls_p::*;
#(
  parameter int REGW   = 5,
  parameter int RA_REG = 31
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            d_valid,
  input  logic            d_regwrite,
  input  logic            d_memwrite,
  input  logic            d_alusrc,
  input  logic            d_branch,
  input  logic            d_jump,
  input  logic            d_jump_r,
  input  logic [1:0]      d_memtoreg,
  input  logic [1:0]      d_regdst,
  input  logic [2:0]      d_alucontrol,
  input  logic [REGW-1:0] d_rs,
  input  logic [REGW-1:0] d_rt,
  input  logic [REGW-1:0] d_rd,
  input  logic            e_zero,
  output logic            e_alusrc,
  output logic [2:0]      e_alucontrol,
  output logic [1:0]      e_forwarda,
  output logic [1:0]      e_forwardb,
  output logic            m_memwrite,
  output logic            w_regwrite,
  output logic [1:0]      w_memtoreg,
  output logic [REGW-1:0] w_writereg,
  output logic            pcsrc,
  output logic            pc_jr,
  output logic            pc_jump,
  output logic            stall_f,
  output logic            stall_d,
  output logic            flush_d
);

  typedef struct packed {
    ctrl_bundle_t    c;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    logic [REGW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic            regwrite;
    memtoreg_t       memtoreg;
    logic            memwrite;
    logic [REGW-1:0] writereg;
  } exmem_t;

  typedef struct packed {
    logic            regwrite;
    memtoreg_t       memtoreg;
    logic [REGW-1:0] writereg;
  } memwb_t;

  localparam idex_t  IDEX_BUBBLE  = '{BUBBLE, '0, '0, '0};
  localparam exmem_t EXMEM_BUBBLE = '{1'b0, MTR_ALU, 1'b0, '0};
  localparam memwb_t MEMWB_BUBBLE = '{1'b0, MTR_ALU, '0};

  function automatic fwd_sel_t fwd_sel(input logic m_rw, input logic [REGW-1:0] m_wr,
                                       input logic w_rw, input logic [REGW-1:0] w_wr,
                                       input logic [REGW-1:0] src);
    if (m_rw && (m_wr != '0) && (m_wr == src)) return FWD_MEM;
    if (w_rw && (w_wr != '0) && (w_wr == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  // run_q keeps ID out of the pipe for the first cycle after reset release
  logic run_q, run_d;
  assign run_d = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= run_d;
  end

  logic         d_live;
  ctrl_bundle_t d_bundle;
  idex_t        idex_d, idex_q;
  exmem_t       exmem_d, exmem_q;
  memwb_t       memwb_d, memwb_q;
  logic [REGW-1:0] e_writereg;
  logic         lw_stall, redirect_e, ctl_in_ex, idex_clr;

  assign d_live = d_valid & run_q;

  always_comb begin
    d_bundle = BUBBLE;
    if (d_live) begin
      d_bundle.valid      = 1'b1;
      d_bundle.regwrite   = d_regwrite;
      d_bundle.memwrite   = d_memwrite;
      d_bundle.alusrc     = d_alusrc;
      d_bundle.branch     = d_branch;
      d_bundle.jump       = d_jump;
      d_bundle.jump_r     = d_jump_r;
      d_bundle.memtoreg   = memtoreg_t'(d_memtoreg);
      d_bundle.regdst     = regdst_t'(d_regdst);
      d_bundle.alucontrol = d_alucontrol;
    end
  end

  always_comb begin
    idex_d    = IDEX_BUBBLE;
    idex_d.c  = d_bundle;
    idex_d.rs = d_live ? d_rs : '0;
    idex_d.rt = d_live ? d_rt : '0;
    idex_d.rd = d_live ? d_rd : '0;
  end

  always_comb begin
    case (idex_q.c.regdst)
      RD_RD:   e_writereg = idex_q.rd;
      RD_RA:   e_writereg = REGW'(RA_REG);
      default: e_writereg = idex_q.rt;
    endcase
  end

  assign pcsrc      = idex_q.c.branch & e_zero;
  assign pc_jr      = idex_q.c.jump_r;
  assign redirect_e = pcsrc | pc_jr;

  // A load is never a branch or jr, so masking on the EX control type rather than on
  // redirect_e gives the same result while keeping e_zero off the stall path.
  assign ctl_in_ex = idex_q.c.branch | idex_q.c.jump_r;
  assign lw_stall  = idex_q.c.valid & idex_q.c.regwrite & (idex_q.c.memtoreg == MTR_MEM) &
                     (e_writereg != '0) & d_live &
                     ((e_writereg == d_rs) | (e_writereg == d_rt)) & ~ctl_in_ex;

  assign pc_jump  = d_live & d_jump & ~redirect_e & ~lw_stall;
  assign flush_d  = redirect_e | pc_jump;
  assign stall_f  = lw_stall;
  assign stall_d  = lw_stall;
  assign idex_clr = redirect_e | lw_stall;

  assign exmem_d = '{idex_q.c.regwrite, idex_q.c.memtoreg, idex_q.c.memwrite, e_writereg};
  assign memwb_d = '{exmem_q.regwrite, exmem_q.memtoreg, exmem_q.writereg};

  ctrl_stage_reg #(.T(idex_t), .RST_VAL(IDEX_BUBBLE)) u_idex (
    .clk(clk), .rst_n(reset_n), .en(1'b1), .clr(idex_clr), .d(idex_d), .q(idex_q)
  );

  ctrl_stage_reg #(.T(exmem_t), .RST_VAL(EXMEM_BUBBLE)) u_exmem (
    .clk(clk), .rst_n(reset_n), .en(1'b1), .clr(1'b0), .d(exmem_d), .q(exmem_q)
  );

  ctrl_stage_reg #(.T(memwb_t), .RST_VAL(MEMWB_BUBBLE)) u_memwb (
    .clk(clk), .rst_n(reset_n), .en(1'b1), .clr(1'b0), .d(memwb_d), .q(memwb_q)
  );

  assign e_forwarda = fwd_sel(exmem_q.regwrite, exmem_q.writereg,
                              memwb_q.regwrite, memwb_q.writereg, idex_q.rs);
  assign e_forwardb = fwd_sel(exmem_q.regwrite, exmem_q.writereg,
                              memwb_q.regwrite, memwb_q.writereg, idex_q.rt);

  assign e_alusrc     = idex_q.c.alusrc;
  assign e_alucontrol = idex_q.c.alucontrol;
  assign m_memwrite   = exmem_q.memwrite;
  assign w_regwrite   = memwb_q.regwrite;
  assign w_memtoreg   = memwb_q.memtoreg;
  assign w_writereg   = memwb_q.writereg;

  logic unused_ex_jump;
  assign unused_ex_jump = idex_q.c.jump;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// tb/tb_mips_ctrl_pipe.sv - self-checking bench for mips_ctrl_pipe against an instruction-level model
module tb_mips_ctrl_pipe;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic       d_valid, d_regwrite, d_memwrite, d_alusrc, d_branch, d_jump, d_jump_r;
  logic [1:0] d_memtoreg, d_regdst;
  logic [2:0] d_alucontrol;
  logic [4:0] d_rs, d_rt, d_rd;
  logic       e_zero;
  logic       e_alusrc, m_memwrite, w_regwrite, pcsrc, pc_jr, pc_jump, stall_f, stall_d, flush_d;
  logic [2:0] e_alucontrol;
  logic [1:0] e_forwarda, e_forwardb, w_memtoreg;
  logic [4:0] w_writereg;

  mips_ctrl_pipe #(.REGW(5), .RA_REG(31)) dut (
    .clk(clk), .reset_n(reset_n),
    .d_valid(d_valid), .d_regwrite(d_regwrite), .d_memwrite(d_memwrite), .d_alusrc(d_alusrc),
    .d_branch(d_branch), .d_jump(d_jump), .d_jump_r(d_jump_r), .d_memtoreg(d_memtoreg),
    .d_regdst(d_regdst), .d_alucontrol(d_alucontrol), .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
    .e_zero(e_zero), .e_alusrc(e_alusrc), .e_alucontrol(e_alucontrol),
    .e_forwarda(e_forwarda), .e_forwardb(e_forwardb), .m_memwrite(m_memwrite),
    .w_regwrite(w_regwrite), .w_memtoreg(w_memtoreg), .w_writereg(w_writereg),
    .pcsrc(pcsrc), .pc_jr(pc_jr), .pc_jump(pc_jump),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
  );

  typedef struct {
    bit       v, rw, mw, as, br, j, jr;
    bit [1:0] mtr, rdst;
    bit [2:0] ac;
    bit [4:0] rs, rt, rd;
  } ins_t;

  // Instructions occupying EX, MEM and WB in the reference model
  ins_t m_ex, m_mem, m_wb, nx_ex;
  bit   m_started;
  bit   exp_stall;
  int   checks = 0;
  int   errors = 0;

  function automatic ins_t nop_ins();
    ins_t i;
    i = '{default: 0};
    return i;
  endfunction

  // kind: 0 bubble, 1 add, 2 lw, 3 sw, 4 beq, 5 j, 6 jal, 7 jr, 8 addi
  function automatic ins_t mk(int kind, int rs, int rt, int rd);
    ins_t i;
    i = nop_ins();
    i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    i.v = (kind != 0);
    case (kind)
      1: begin i.rw = 1; i.rdst = 2'd1; i.ac = 3'b010; end
      2: begin i.rw = 1; i.as = 1; i.mtr = 2'd1; i.ac = 3'b010; end
      3: begin i.mw = 1; i.as = 1; i.ac = 3'b010; end
      4: begin i.br = 1; i.ac = 3'b110; end
      5: i.j = 1;
      6: begin i.j = 1; i.rw = 1; i.mtr = 2'd2; i.rdst = 2'd2; end
      7: i.jr = 1;
      8: begin i.rw = 1; i.as = 1; i.ac = 3'b010; end
      default: ;
    endcase
    return i;
  endfunction

  function automatic bit [4:0] dest(ins_t i);
    if (i.rdst == 2'd1) return i.rd;
    if (i.rdst == 2'd2) return 5'd31;
    return i.rt;
  endfunction

  function automatic bit [1:0] fwd(bit [4:0] r);
    if (m_mem.rw && dest(m_mem) != 0 && dest(m_mem) == r) return 2'b10;
    if (m_wb.rw && dest(m_wb) != 0 && dest(m_wb) == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int rreg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 31 : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(ins_t i);
    d_valid = i.v; d_regwrite = i.rw; d_memwrite = i.mw; d_alusrc = i.as;
    d_branch = i.br; d_jump = i.j; d_jump_r = i.jr;
    d_memtoreg = i.mtr; d_regdst = i.rdst; d_alucontrol = i.ac;
    d_rs = i.rs; d_rt = i.rt; d_rd = i.rd;
  endtask

  task automatic model_reset();
    m_ex = nop_ins(); m_mem = nop_ins(); m_wb = nop_ins(); nx_ex = nop_ins();
    m_started = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_e_alusrc"}, 32'(e_alusrc), 0);
    chk({tag, "_e_alucontrol"}, 32'(e_alucontrol), 0);
    chk({tag, "_e_forwarda"}, 32'(e_forwarda), 0);
    chk({tag, "_e_forwardb"}, 32'(e_forwardb), 0);
    chk({tag, "_m_memwrite"}, 32'(m_memwrite), 0);
    chk({tag, "_w_regwrite"}, 32'(w_regwrite), 0);
    chk({tag, "_w_memtoreg"}, 32'(w_memtoreg), 0);
    chk({tag, "_w_writereg"}, 32'(w_writereg), 0);
    chk({tag, "_pcsrc"}, 32'(pcsrc), 0);
    chk({tag, "_pc_jr"}, 32'(pc_jr), 0);
    chk({tag, "_pc_jump"}, 32'(pc_jump), 0);
    chk({tag, "_stall_f"}, 32'(stall_f), 0);
    chk({tag, "_stall_d"}, 32'(stall_d), 0);
    chk({tag, "_flush_d"}, 32'(flush_d), 0);
  endtask

  // Drive ID, then at the falling edge compare every output with the model's prediction
  task automatic present(ins_t d, bit z);
    bit dv, redir, lw, pcj;
    drive(d);
    e_zero = z;
    @(negedge clk);
    dv    = d.v & m_started;
    redir = (m_ex.br & z) | m_ex.jr;
    lw    = m_ex.v & m_ex.rw & (m_ex.mtr == 2'd1) & (dest(m_ex) != 0) & dv &
            ((dest(m_ex) == d.rs) | (dest(m_ex) == d.rt)) & ~redir;
    pcj   = dv & d.j & ~redir & ~lw;
    chk("m_e_alusrc", 32'(e_alusrc), 32'(m_ex.as));
    chk("m_e_alucontrol", 32'(e_alucontrol), 32'(m_ex.ac));
    chk("m_e_forwarda", 32'(e_forwarda), 32'(fwd(m_ex.rs)));
    chk("m_e_forwardb", 32'(e_forwardb), 32'(fwd(m_ex.rt)));
    chk("m_m_memwrite", 32'(m_memwrite), 32'(m_mem.mw));
    chk("m_w_regwrite", 32'(w_regwrite), 32'(m_wb.rw));
    chk("m_w_memtoreg", 32'(w_memtoreg), 32'(m_wb.mtr));
    chk("m_w_writereg", 32'(w_writereg), 32'(dest(m_wb)));
    chk("m_pcsrc", 32'(pcsrc), 32'(m_ex.br & z));
    chk("m_pc_jr", 32'(pc_jr), 32'(m_ex.jr));
    chk("m_pc_jump", 32'(pc_jump), 32'(pcj));
    chk("m_stall_f", 32'(stall_f), 32'(lw));
    chk("m_stall_d", 32'(stall_d), 32'(lw));
    chk("m_flush_d", 32'(flush_d), 32'(redir | pcj));
    nx_ex     = (redir || lw || !dv) ? nop_ins() : d;
    exp_stall = lw;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_wb = m_mem; m_mem = m_ex; m_ex = nx_ex;
    m_started = 1;
  endtask

  task automatic drain();
    repeat (3) begin present(mk(0, 0, 0, 0), 0); advance(); end
  endtask

  initial begin
    ins_t cur;
    bit   hold;
    reset_n = 1'b0;
    drive(mk(6, 5, 6, 7));
    e_zero = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_init");
    reset_n = 1'b1;
    present(mk(0, 0, 0, 0), 0); advance();
    drain();

    // lw $t0 then dependent add: one stall, bubble in EX, then forward from WB
    present(mk(2, 1, 8, 0), 0); advance();
    present(mk(1, 8, 10, 9), 0);
    chk("lu_stall_f", 32'(stall_f), 1);
    chk("lu_stall_d", 32'(stall_d), 1);
    advance();
    present(mk(1, 8, 10, 9), 0);
    chk("lu_once", 32'(stall_f), 0);
    chk("lu_bubble_alu", 32'(e_alucontrol), 0);
    advance();
    present(mk(0, 0, 0, 0), 0);
    chk("lu_fwd_wb", 32'(e_forwarda), 1);
    advance();
    drain();

    // back-to-back forwarding from MEM
    present(mk(1, 1, 2, 8), 0); advance();
    present(mk(1, 8, 8, 9), 0); advance();
    present(mk(0, 0, 0, 0), 0);
    chk("fwd_mem_a", 32'(e_forwarda), 2);
    chk("fwd_mem_b", 32'(e_forwardb), 2);
    advance();
    drain();

    // one unrelated instruction between -> forward from WB
    present(mk(1, 1, 2, 8), 0); advance();
    present(mk(1, 1, 2, 11), 0); advance();
    present(mk(1, 8, 8, 9), 0); advance();
    present(mk(0, 0, 0, 0), 0);
    chk("fwd_wb_a", 32'(e_forwarda), 1);
    chk("fwd_wb_b", 32'(e_forwardb), 1);
    advance();
    drain();

    // MEM beats WB on a double match; $0 never forwards
    present(mk(1, 1, 2, 8), 0); advance();
    present(mk(1, 1, 2, 8), 0); advance();
    present(mk(1, 8, 0, 9), 0); advance();
    present(mk(0, 0, 0, 0), 0);
    chk("fwd_prio", 32'(e_forwarda), 2);
    chk("fwd_zero", 32'(e_forwardb), 0);
    advance();
    drain();

    // taken beq in EX flushes the following add
    present(mk(2, 1, 8, 0), 0); advance();
    present(mk(4, 1, 2, 0), 0); advance();
    present(mk(1, 8, 8, 9), 1);
    chk("beq_pcsrc", 32'(pcsrc), 1);
    chk("beq_flush", 32'(flush_d), 1);
    chk("beq_nostall", 32'(stall_f), 0);
    advance();
    present(mk(0, 0, 0, 0), 0);
    chk("beq_bubble", 32'(e_alucontrol), 0);
    advance();
    drain();

    // jal reaches WB writing $31 with pc+4
    present(mk(6, 0, 0, 0), 0);
    chk("jal_pc_jump", 32'(pc_jump), 1);
    chk("jal_flush", 32'(flush_d), 1);
    advance();
    repeat (2) begin present(mk(0, 0, 0, 0), 0); advance(); end
    present(mk(0, 0, 0, 0), 0);
    chk("jal_w_writereg", 32'(w_writereg), 31);
    chk("jal_w_memtoreg", 32'(w_memtoreg), 2);
    chk("jal_w_regwrite", 32'(w_regwrite), 1);
    advance();
    drain();

    // jr in EX overrides j in ID
    present(mk(7, 3, 0, 0), 0); advance();
    present(mk(5, 0, 0, 0), 0);
    chk("jr_pc_jr", 32'(pc_jr), 1);
    chk("jr_pc_jump", 32'(pc_jump), 0);
    chk("jr_flush", 32'(flush_d), 1);
    advance();
    present(mk(0, 0, 0, 0), 0);
    chk("jr_bubble", 32'(pc_jr), 0);
    advance();

    // randomized stream; ID is re-presented while stalled
    cur = mk($urandom_range(0, 8), rreg(), rreg(), rreg());
    for (int n = 0; n < 400; n++) begin
      present(cur, 1'($urandom_range(0, 1)));
      hold = exp_stall;
      advance();
      if (!hold) cur = mk($urandom_range(0, 8), rreg(), rreg(), rreg());
    end
    drain();

    // async reset mid-stream with a lw in EX
    present(mk(2, 1, 8, 0), 0); advance();
    present(mk(1, 8, 10, 9), 0);
    chk("rst_pre_stall", 32'(stall_f), 1);
    #2;
    reset_n = 1'b0;
    drive(mk(6, 0, 0, 0));
    #1;
    check_all_zero("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    reset_n = 1'b1;
    present(mk(6, 0, 0, 0), 0);
    chk("rst_first_cycle", 32'(pc_jump), 0);
    advance();
    present(mk(6, 0, 0, 0), 0);
    chk("rst_restart_jal", 32'(pc_jump), 1);
    advance();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
